seg_scan_decoder: RTL and testbench

//   Receive-side counterpart of the multiplexed 7-segment display driver.

---
 rtl/seg_scan_pkg.sv | 67 ++++++
 rtl/seg_scan_decoder_if.sv | 17 +
 rtl/seg7_to_hex.sv | 19 +
 rtl/seg_scan_decoder.sv | 198 +++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// seg_scan_pkg : glyph constants, accept classification and glyph decoder
// Rev 1.0
// ============================================================================
package seg_scan_pkg;

  localparam int DIGITS_DEFAULT = 10;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_BLANK = 2'd1,
    ACC_ERR   = 2'd2,
    ACC_DIGIT = 2'd3
  } acc_kind_t;

  typedef struct packed {
    logic       known;
    logic [3:0] nibble;
  } seg_dec_t;

  // Unrecognised patterns, including a dark digit, decode to nibble 0 / unknown.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    r.known  = 1'b1;
    r.nibble = 4'h0;
    case (seg)
      SEG_0:   r.nibble = 4'h0;
      SEG_1:   r.nibble = 4'h1;
      SEG_2:   r.nibble = 4'h2;
      SEG_3:   r.nibble = 4'h3;
      SEG_4:   r.nibble = 4'h4;
      SEG_5:   r.nibble = 4'h5;
      SEG_6:   r.nibble = 4'h6;
      SEG_7:   r.nibble = 4'h7;
      SEG_8:   r.nibble = 4'h8;
      SEG_9:   r.nibble = 4'h9;
      SEG_A:   r.nibble = 4'hA;
      SEG_B:   r.nibble = 4'hB;
      SEG_C:   r.nibble = 4'hC;
      SEG_D:   r.nibble = 4'hD;
      SEG_E:   r.nibble = 4'hE;
      SEG_F:   r.nibble = 4'hF;
      default: r.known  = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// seg_scan_decoder_if : multiplexed display pin bus (segments + digit select)
// Rev 1.0
// ============================================================================
interface seg_scan_decoder_if
  import seg_scan_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
);
  logic [7:0]        segm_in;
  logic [DIGITS-1:0] sel_in;

  modport master (output segm_in, output sel_in);
  modport slave  (input  segm_in, input  sel_in);
endinterface
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
// seg7_to_hex : combinational 7-segment glyph to hex nibble decoder
// Rev 1.0
// ============================================================================
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       known_o
);
  seg_dec_t w_dec;

  assign w_dec    = seg_decode(seg_i);
  assign nibble_o = w_dec.nibble;
  assign known_o  = w_dec.known;
endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg_scan_decoder : samples a scanned 7-segment bus, filters glitches and
//                    publishes fully captured frames atomically
// Rev 1.0
// ============================================================================
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int DIGITS        = DIGITS_DEFAULT,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  seg_scan_decoder_if.slave       pins_i,
  output logic [4*DIGITS-1:0]     digit_o,
  output logic [DIGITS-1:0]       dp_o,
  output logic [DIGITS-1:0]       known_o,
  output logic                    frame_o,
  output logic                    err_o,
  output logic                    stale_o
);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [STAB_W-1:0] STAB_SAT = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_SAT   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  logic [7:0]          segm_s1_q, segm_s2_q, segm_prev_q;
  logic [DIGITS-1:0]   sel_s1_q, sel_s2_q, sel_prev_q;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   sdp_q, sdp_d;
  logic [DIGITS-1:0]   skn_q, skn_d;

  logic [4*DIGITS-1:0] digit_q, digit_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   known_q, known_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;
  logic                stale_q, stale_d;

  logic                w_same;
  logic                w_accept;
  logic                w_single;
  logic                w_already;
  logic                w_capture;
  logic                w_timeout;
  logic                w_complete;
  acc_kind_t           w_kind;
  logic [3:0]          w_nib;
  logic                w_known;

  seg7_to_hex u_dec (
    .seg_i    (segm_s2_q[6:0]),
    .nibble_o (w_nib),
    .known_o  (w_known)
  );

  // Input path: two-flop synchronizer plus one delayed copy for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segm_s1_q   <= '0;
      segm_s2_q   <= '0;
      segm_prev_q <= '0;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      sel_prev_q  <= '0;
      stab_cnt_q  <= '0;
    end else begin
      segm_s1_q   <= pins_i.segm_in;
      segm_s2_q   <= segm_s1_q;
      segm_prev_q <= segm_s2_q;
      sel_s1_q    <= pins_i.sel_in;
      sel_s2_q    <= sel_s1_q;
      sel_prev_q  <= sel_s2_q;
      stab_cnt_q  <= stab_cnt_d;
    end
  end

  // Counter saturates one above the hit value so accept fires once per run.
  always_comb begin
    w_same     = (sel_s2_q == sel_prev_q) && (segm_s2_q == segm_prev_q);
    stab_cnt_d = '0;
    if (w_same) begin
      stab_cnt_d = (stab_cnt_q == STAB_SAT) ? stab_cnt_q : stab_cnt_q + 1'b1;
    end
  end

  assign w_accept   = (stab_cnt_d == STAB_HIT);
  assign w_single   = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - 1'b1)) == '0);
  assign w_already  = |(sel_s2_q & mask_q);
  assign w_complete = &mask_q;

  always_comb begin
    w_kind = ACC_NONE;
    if (w_accept) begin
      if (sel_s2_q == '0) begin
        w_kind = ACC_BLANK;
      end else if (!w_single) begin
        w_kind = ACC_ERR;
      end else begin
        w_kind = ACC_DIGIT;
      end
    end
  end

  assign w_capture = (w_kind == ACC_DIGIT) && !w_already;
  assign w_timeout = !w_capture && (to_cnt_q == TO_LAST);

  always_comb begin
    mask_d   = mask_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    skn_d    = skn_q;
    digit_d  = digit_q;
    dp_d     = dp_q;
    known_d  = known_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    stale_d  = stale_q;
    to_cnt_d = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + 1'b1;

    if (w_capture) begin
      to_cnt_d = '0;
      for (int k = 0; k < DIGITS; k++) begin
        if (sel_s2_q[k]) begin
          shadow_d[4*k +: 4] = w_nib;
          sdp_d[k]           = segm_s2_q[7];
          skn_d[k]           = w_known;
          mask_d[k]          = 1'b1;
        end
      end
    end

    if (w_kind == ACC_ERR) begin
      err_d  = 1'b1;
      mask_d = '0;
    end

    if (w_timeout) begin
      mask_d  = '0;
      stale_d = 1'b1;
    end

    // Completion overrides a coincident timeout so a fresh frame is never stale.
    if (w_complete) begin
      digit_d = shadow_q;
      dp_d    = sdp_q;
      known_d = skn_q;
      frame_d = 1'b1;
      mask_d  = '0;
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      skn_q    <= '0;
      digit_q  <= '0;
      dp_q     <= '0;
      known_q  <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      skn_q    <= skn_d;
      digit_q  <= digit_d;
      dp_q     <= dp_d;
      known_q  <= known_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
    end
  end

  assign digit_o = digit_q;
  assign dp_o    = dp_q;
  assign known_o = known_q;
  assign frame_o = frame_q;
  assign err_o   = err_q;
  assign stale_o = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_decoder : directed scenarios plus random scan traffic, compared
//                       every cycle against a behavioural frame model
// Rev 1.0
// ============================================================================
module tb_seg_scan_decoder;
  localparam int DIGITS = 10;
  localparam int STABLE = 4;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  logic [4*DIGITS-1:0] digit_o;
  logic [DIGITS-1:0]   dp_o;
  logic [DIGITS-1:0]   known_o;
  logic                frame_o;
  logic                err_o;
  logic                stale_o;

  seg_scan_decoder #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE),
    .TIMEOUT       (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pins_i  (bus),
    .digit_o (digit_o),
    .dp_o    (dp_o),
    .known_o (known_o),
    .frame_o (frame_o),
    .err_o   (err_o),
    .stale_o (stale_o)
  );

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_err    = 0;
  int frame_seen = 0;
  int err_seen   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DIGITS+7:0]   hist[$];
  logic [DIGITS-1:0]   m_mask, m_sdp, m_skn, m_dp, m_known;
  logic [4*DIGITS-1:0] m_shadow, m_digit;
  logic                m_frame, m_err, m_stale, m_pend;
  int                  m_cyc, m_last_cap;

  function automatic int glyph_index(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == g) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    m_mask = '0; m_sdp = '0; m_skn = '0; m_dp = '0; m_known = '0;
    m_shadow = '0; m_digit = '0;
    m_frame = 1'b0; m_err = 1'b0; m_stale = 1'b0; m_pend = 1'b0;
    m_cyc = 0; m_last_cap = 0;
  endtask

  // A pin pattern is taken once it has been seen, two cycles late, exactly STABLE times in a row.
  task automatic model_step(input logic [DIGITS+7:0] p);
    logic [DIGITS+7:0] v;
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;
    int run, ones, k, gi;
    logic complete;
    hist.push_back(p);
    if (hist.size() > STABLE + 4) void'(hist.pop_front());
    m_cyc++;
    v   = hist[hist.size()-3];
    run = 0;
    for (int j = hist.size() - 3; j >= 0 && hist[j] == v; j--) run++;
    m_frame  = 1'b0;
    m_err    = 1'b0;
    complete = m_pend;
    if (run == STABLE) begin
      sel  = v[DIGITS+7:8];
      seg  = v[7:0];
      ones = $countones(sel);
      if (ones > 1) begin
        m_err  = 1'b1;
        m_mask = '0;
      end else if (ones == 1) begin
        k = 0;
        for (int i = 0; i < DIGITS; i++) if (sel[i]) k = i;
        if (!m_mask[k]) begin
          gi = glyph_index(seg[6:0]);
          m_shadow[4*k +: 4] = (gi < 0) ? 4'h0 : gi[3:0];
          m_skn[k]  = (gi >= 0);
          m_sdp[k]  = seg[7];
          m_mask[k] = 1'b1;
          m_last_cap = m_cyc;
        end
      end
    end
    if (!complete && (m_cyc - m_last_cap == TMO)) begin
      m_mask  = '0;
      m_stale = 1'b1;
    end
    if (complete) begin
      m_digit = m_shadow;
      m_dp    = m_sdp;
      m_known = m_skn;
      m_frame = 1'b1;
      m_mask  = '0;
      m_stale = 1'b0;
    end
    m_pend = (m_mask == '1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step({bus.sel_in, bus.segm_in});
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("out_data",  {digit_o, dp_o, known_o}, {m_digit, m_dp, m_known});
      check("out_flags", {frame_o, err_o, stale_o}, {m_frame, m_err, m_stale});
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst === 1'b0) begin
      if (frame_o) frame_seen++;
      if (err_o)   err_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [DIGITS-1:0] s, input logic [7:0] g, input int n);
    bus.sel_in  = s;
    bus.segm_in = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int first, input int last, input int hold);
    for (int d = first; d <= last; d++) drive(DIGITS'(1) << d, {1'b0, glyph_tab[d]}, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0, e0;
    logic [DIGITS-1:0] s;
    logic [7:0] g;
    int hold;

    bus.sel_in  = '0;
    bus.segm_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {digit_o, dp_o, known_o, frame_o, err_o, stale_o}, 64'h0);
    rst = 1'b0;
    drive('0, 8'h00, 4);

    // 1: clean scan, frame latency measured from the last digit's pin change
    f0 = frame_seen;
    scan(0, 8, 8);
    bus.sel_in  = DIGITS'(1) << 9;
    bus.segm_in = {1'b0, glyph_tab[9]};
    repeat (6) @(negedge clk);
    check("latency_early", frame_o, 1'b0);
    @(negedge clk);
    check("latency_frame", frame_o, 1'b1);
    drive('0, 8'h00, 3);
    check("t1_digits", digit_o, 40'h9876543210);
    check("t1_known",  known_o, 10'h3FF);
    check("t1_model",  m_digit, 40'h9876543210);
    check("t1_frames", frame_seen - f0, 1);

    // 2: short glitches between digits never get accepted
    f0 = frame_seen;
    for (int d = 0; d < DIGITS; d++) begin
      drive(DIGITS'(1) << d, {1'b0, glyph_tab[d]}, 8);
      if (d == 1 || d == 6) drive(10'h004, 8'h79, 2);
    end
    drive('0, 8'h00, 3);
    check("t2_digits", digit_o, 40'h9876543210);
    check("t2_frames", frame_seen - f0, 1);

    // 3: decimal point and an illegal glyph
    for (int d = 0; d < DIGITS; d++) begin
      g = (d == 5) ? 8'hFD : (d == 3) ? 8'h49 : {1'b0, glyph_tab[d]};
      drive(DIGITS'(1) << d, g, 8);
    end
    drive('0, 8'h00, 3);
    check("t3_digits", digit_o, 40'h9876640210);
    check("t3_known",  known_o, 10'h3F7);
    check("t3_dp",     dp_o,    10'h020);

    // 4: multi-hot select restarts the frame
    scan(0, 4, 8);
    e0 = err_seen;
    f0 = frame_seen;
    drive(10'h003, 8'h3F, 8);
    drive('0, 8'h00, 2);
    check("t4_err_pulses", err_seen - e0, 1);
    scan(5, 9, 8);
    drive('0, 8'h00, 3);
    check("t4_no_frame", frame_seen - f0, 0);
    scan(0, 4, 8);
    drive('0, 8'h00, 3);
    check("t4_frame", frame_seen - f0, 1);
    check("t4_digits", digit_o, 40'h9876543210);

    // 5: scanning stops after six digits
    f0 = frame_seen;
    scan(0, 4, 8);
    bus.sel_in  = DIGITS'(1) << 5;
    bus.segm_in = {1'b0, glyph_tab[5]};
    repeat (8) @(negedge clk);
    bus.sel_in  = '0;
    bus.segm_in = 8'h00;
    repeat (61) @(negedge clk);
    check("t5_stale_early", stale_o, 1'b0);
    @(negedge clk);
    check("t5_stale", stale_o, 1'b1);
    check("t5_digits_kept", digit_o, 40'h9876543210);
    check("t5_no_frame", frame_seen - f0, 0);
    scan(0, 9, 8);
    drive('0, 8'h00, 3);
    check("t5_rescan_frame", frame_seen - f0, 1);
    check("t5_stale_clear", stale_o, 1'b0);

    // 6: asynchronous reset part way through a frame
    scan(0, 6, 8);
    bus.sel_in  = '0;
    bus.segm_in = 8'h00;
    #1 rst = 1'b1;
    #1 check("t6_rst_async", {digit_o, dp_o, known_o, frame_o, err_o, stale_o}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = frame_seen;
    drive('0, 8'h00, 2);
    scan(0, 9, 8);
    drive('0, 8'h00, 3);
    check("t6_frames", frame_seen - f0, 1);
    check("t6_digits", digit_o, 40'h9876543210);

    // random traffic: mostly one-hot selects with legal glyphs, some blanking,
    // multi-hot selects, junk patterns, short glitches and long idles
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 19))
        0:       s = '0;
        1:       s = DIGITS'($urandom) | (DIGITS'(3) << $urandom_range(0, DIGITS - 2));
        default: s = DIGITS'(1) << $urandom_range(0, DIGITS - 1);
      endcase
      if ($urandom_range(0, 9) == 0) g = 8'($urandom);
      else g = {1'($urandom_range(0, 1)), glyph_tab[$urandom_range(0, 15)]};
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) hold = TMO + 6;
      drive(s, g, hold);
    end
    drive('0, 8'h00, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
